pipeline_scoreboard: RTL and testbench

//  Issue controller between ID and EX of the core. Tracks outstanding register writes per

---
 rtl/pipeline_scoreboard_pkg.sv | 15 +
 rtl/pipeline_scoreboard_sb_counter.sv | 39 +++
 rtl/pipeline_scoreboard.sv | 144 ++++++++++++++
 tb/tb_pipeline_scoreboard.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_scoreboard_pkg.sv
// rtl/pipeline_scoreboard_pkg.sv - shared sizes and FSM state encodings for the issue scoreboard
package pipeline_scoreboard_pkg;

    localparam int SB_NREG      = 16;
    localparam int SB_NAME_W    = 4;
    localparam int SB_CNT_W     = 2;
    localparam int SB_FLUSH_CYC = 1;

    typedef enum logic [1:0] {
        SB_RUN   = 2'd0,
        SB_FLUSH = 2'd1,
        SB_DRAIN = 2'd2
    } sb_state_e;

endpackage

// File: rtl/pipeline_scoreboard_sb_counter.sv
// rtl/pipeline_scoreboard_sb_counter.sv - per-register outstanding-write counter
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic dec_i,
    output logic zero_o,
    output logic max_o,
    output logic underflow_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign zero_o      = (cnt_q == '0);
    assign max_o       = (cnt_q == {CNT_W{1'b1}});
    // A retire that is not offset by a same-cycle reserve on an idle register is illegal.
    assign underflow_o = dec_i & ~inc_i & zero_o;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i && !max_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec_i && !inc_i && !zero_o) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pipeline_scoreboard.sv
// rtl/pipeline_scoreboard.sv - ID->EX issue controller with RAW tracking, branch squash and drain
module pipeline_scoreboard
    import pipeline_scoreboard_pkg::*;
#(
    parameter int NREG      = SB_NREG,
    parameter int NAME_W    = SB_NAME_W,
    parameter int CNT_W     = SB_CNT_W,
    parameter int FLUSH_CYC = SB_FLUSH_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_v_i,
    input  logic              id_rd_read_i,
    input  logic              id_rs_read_i,
    input  logic              id_rd_wb_i,
    input  logic [NAME_W-1:0] id_rd_name_i,
    input  logic [NAME_W-1:0] id_rs_name_i,
    input  logic              ex_busy_i,
    input  logic              wb_i,
    input  logic [NAME_W-1:0] wb_rd_name_i,
    input  logic              branch_i,
    input  logic              drain_req_i,
    output logic              issue_o,
    output logic              stall_idif_o,
    output logic              flush_o,
    output logic              rd_reserved_o,
    output logic              rs_reserved_o,
    output logic [NREG-1:0]   busy_vec_o,
    output logic              drain_done_o,
    output logic              err_o
);

    localparam int FC_W = (FLUSH_CYC < 2) ? 1 : $clog2(FLUSH_CYC + 1);
    localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYC);

    sb_state_e       state_q, state_d;
    logic [FC_W-1:0] fcnt_q, fcnt_d;
    logic            err_q, err_d;

    logic [NREG-1:0] zero_vec, max_vec, unf_vec, inc_vec, dec_vec;
    logic            rd_haz, rs_haz, sat;
    logic            issue, stall, flush, done;

    genvar g;
    generate
        for (g = 0; g < NREG; g++) begin : g_cnt
            assign inc_vec[g] = issue & id_rd_wb_i & (id_rd_name_i == NAME_W'(g));
            assign dec_vec[g] = wb_i & (wb_rd_name_i == NAME_W'(g));
            sb_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk         (clk),
                .rst         (rst),
                .inc_i       (inc_vec[g]),
                .dec_i       (dec_vec[g]),
                .zero_o      (zero_vec[g]),
                .max_o       (max_vec[g]),
                .underflow_o (unf_vec[g])
            );
        end
    endgenerate

    // Hazards look only at registered counts: a retire becomes visible the following cycle.
    assign rd_haz = id_rd_read_i & ~zero_vec[id_rd_name_i];
    assign rs_haz = id_rs_read_i & ~zero_vec[id_rs_name_i];
    assign sat    = id_rd_wb_i & max_vec[id_rd_name_i];

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        issue   = 1'b0;
        stall   = 1'b0;
        flush   = 1'b0;
        done    = 1'b0;
        case (state_q)
            SB_RUN: begin
                issue = id_v_i & ~rd_haz & ~rs_haz & ~sat & ~ex_busy_i & ~branch_i;
                stall = id_v_i & ~issue & ~branch_i;
                flush = branch_i;
                if (branch_i) begin
                    state_d = SB_FLUSH;
                    fcnt_d  = FC_LOAD;
                end else if (drain_req_i) begin
                    state_d = SB_DRAIN;
                end
            end
            SB_FLUSH: begin
                flush = 1'b1;
                if (branch_i) begin
                    fcnt_d = FC_LOAD;
                end else if (fcnt_q <= FC_W'(1)) begin
                    state_d = SB_RUN;
                    fcnt_d  = '0;
                end else begin
                    fcnt_d = fcnt_q - FC_W'(1);
                end
            end
            SB_DRAIN: begin
                stall = id_v_i;
                flush = branch_i;
                if (branch_i) begin
                    state_d = SB_FLUSH;
                    fcnt_d  = FC_LOAD;
                end else if ((&zero_vec) && !wb_i) begin
                    done    = 1'b1;
                    state_d = SB_RUN;
                end
            end
            default: begin
                state_d = SB_RUN;
                fcnt_d  = '0;
            end
        endcase
        // Outputs driven straight from inputs must also read 0 while reset is held.
        if (!rst) begin
            issue = 1'b0;
            stall = 1'b0;
            flush = 1'b0;
            done  = 1'b0;
        end
    end

    assign err_d = err_q | (|unf_vec);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SB_RUN;
            fcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            err_q   <= err_d;
        end
    end

    assign issue_o       = issue;
    assign stall_idif_o  = stall;
    assign flush_o       = flush;
    assign drain_done_o  = done;
    assign busy_vec_o    = ~zero_vec;
    assign rd_reserved_o = ~zero_vec[id_rd_name_i];
    assign rs_reserved_o = ~zero_vec[id_rs_name_i];
    assign err_o         = err_q;

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// tb/tb_pipeline_scoreboard.sv - directed and randomized self-checking bench for pipeline_scoreboard
module tb_pipeline_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_v_i, id_rd_read_i, id_rs_read_i, id_rd_wb_i;
    logic [3:0]  id_rd_name_i, id_rs_name_i, wb_rd_name_i;
    logic        ex_busy_i, wb_i, branch_i, drain_req_i;
    logic        issue_o, stall_idif_o, flush_o, rd_reserved_o, rs_reserved_o;
    logic [15:0] busy_vec_o;
    logic        drain_done_o, err_o;
    logic [3:0]  ctl;

    int n_checks = 0;
    int n_pass   = 0;

    pipeline_scoreboard dut (
        .clk           (clk),
        .rst           (rst),
        .id_v_i        (id_v_i),
        .id_rd_read_i  (id_rd_read_i),
        .id_rs_read_i  (id_rs_read_i),
        .id_rd_wb_i    (id_rd_wb_i),
        .id_rd_name_i  (id_rd_name_i),
        .id_rs_name_i  (id_rs_name_i),
        .ex_busy_i     (ex_busy_i),
        .wb_i          (wb_i),
        .wb_rd_name_i  (wb_rd_name_i),
        .branch_i      (branch_i),
        .drain_req_i   (drain_req_i),
        .issue_o       (issue_o),
        .stall_idif_o  (stall_idif_o),
        .flush_o       (flush_o),
        .rd_reserved_o (rd_reserved_o),
        .rs_reserved_o (rs_reserved_o),
        .busy_vec_o    (busy_vec_o),
        .drain_done_o  (drain_done_o),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    assign ctl = {issue_o, stall_idif_o, flush_o, drain_done_o};

    task automatic idle();
        id_v_i = 0; id_rd_read_i = 0; id_rs_read_i = 0; id_rd_wb_i = 0;
        id_rd_name_i = 0; id_rs_name_i = 0; ex_busy_i = 0; wb_i = 0;
        wb_rd_name_i = 0; branch_i = 0; drain_req_i = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_init();
        rst = 0;
        idle();
        id_v_i = 1; branch_i = 1; drain_req_i = 1; wb_i = 1;
        #2;
        n_checks++;
        if ({ctl, rd_reserved_o, rs_reserved_o, err_o, busy_vec_o} !== 23'h0)
            $display("FAIL reset_init got %h want 0", {ctl, rd_reserved_o, rs_reserved_o, err_o, busy_vec_o});
        else n_pass++;
        step(); step();
        rst = 1;
        idle();
        #2;
    endtask

    task automatic test_raw();
        id_v_i = 1; id_rd_wb_i = 1; id_rd_name_i = 3;
        #2; n_checks++;
        if (ctl !== 4'b1000) $display("FAIL raw_first_issue got %b want 1000", ctl); else n_pass++;
        step();
        id_rd_wb_i = 0; id_rd_name_i = 4; id_rs_read_i = 1; id_rs_name_i = 3;
        #2; n_checks++;
        if ({ctl, rs_reserved_o, busy_vec_o} !== {4'b0100, 1'b1, 16'h0008})
            $display("FAIL raw_stall got %h want %h", {ctl, rs_reserved_o, busy_vec_o}, {4'b0100, 1'b1, 16'h0008});
        else n_pass++;
        step();
        wb_i = 1; wb_rd_name_i = 3;
        #2; n_checks++;
        if (ctl !== 4'b0100) $display("FAIL raw_no_bypass got %b want 0100", ctl); else n_pass++;
        step();
        wb_i = 0;
        #2; n_checks++;
        if ({ctl, busy_vec_o} !== {4'b1000, 16'h0}) $display("FAIL raw_release got %h want 80000", {ctl, busy_vec_o}); else n_pass++;
        step();
        idle();
    endtask

    task automatic test_saturation();
        id_v_i = 1; id_rd_wb_i = 1; id_rd_name_i = 5;
        for (int i = 0; i < 3; i++) begin
            #2; n_checks++;
            if (ctl !== 4'b1000) $display("FAIL sat_fill%0d got %b want 1000", i, ctl); else n_pass++;
            step();
        end
        #2; n_checks++;
        if ({ctl, rd_reserved_o, busy_vec_o} !== {4'b0100, 1'b1, 16'h0020})
            $display("FAIL sat_stall got %h want %h", {ctl, rd_reserved_o, busy_vec_o}, {4'b0100, 1'b1, 16'h0020});
        else n_pass++;
        wb_i = 1; wb_rd_name_i = 5;
        #2; n_checks++;
        if (ctl !== 4'b0100) $display("FAIL sat_stall_wb got %b want 0100", ctl); else n_pass++;
        step();
        #2; n_checks++;
        if (ctl !== 4'b1000) $display("FAIL sat_inc_dec got %b want 1000", ctl); else n_pass++;
        step();
        wb_i = 0;
        #2; n_checks++;
        if (ctl !== 4'b1000) $display("FAIL sat_refill got %b want 1000", ctl); else n_pass++;
        step();
        #2; n_checks++;
        if (ctl !== 4'b0100) $display("FAIL sat_full_again got %b want 0100", ctl); else n_pass++;
        idle();
        wb_i = 1; wb_rd_name_i = 5;
        repeat (3) step();
        wb_i = 0;
        #2; n_checks++;
        if (busy_vec_o !== 16'h0) $display("FAIL sat_empty got %h want 0000", busy_vec_o); else n_pass++;
        step();
    endtask

    task automatic test_branch();
        id_v_i = 1; id_rd_wb_i = 1; id_rd_name_i = 8;
        #2; n_checks++;
        if (ctl !== 4'b1000) $display("FAIL br_pre_issue got %b want 1000", ctl); else n_pass++;
        step();
        id_rd_name_i = 6; branch_i = 1;
        #2; n_checks++;
        if (ctl !== 4'b0010) $display("FAIL br_sample got %b want 0010", ctl); else n_pass++;
        step();
        branch_i = 0; wb_i = 1; wb_rd_name_i = 8;
        #2; n_checks++;
        if (ctl !== 4'b0010) $display("FAIL br_flush got %b want 0010", ctl); else n_pass++;
        step();
        wb_i = 0; id_rd_wb_i = 0; id_rd_read_i = 1;
        #2; n_checks++;
        if ({ctl, busy_vec_o} !== {4'b1000, 16'h0}) $display("FAIL br_after got %h want 80000", {ctl, busy_vec_o}); else n_pass++;
        step();
        idle();
    endtask

    task automatic test_drain();
        logic [3:0] want [0:4];
        want = '{4'b0100, 4'b0100, 4'b0100, 4'b0101, 4'b1000};
        id_v_i = 1; id_rd_wb_i = 1; id_rd_name_i = 1;
        step();
        id_rd_name_i = 2;
        step();
        id_v_i = 0; drain_req_i = 1;
        #2; n_checks++;
        if (ctl !== 4'b0000) $display("FAIL drain_req got %b want 0000", ctl); else n_pass++;
        step();
        drain_req_i = 0; id_v_i = 1; id_rd_name_i = 9;
        #2; n_checks++;
        if (busy_vec_o !== 16'h0006) $display("FAIL drain_busy got %h want 0006", busy_vec_o); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            wb_i = (i == 1) || (i == 2);
            wb_rd_name_i = (i == 1) ? 4'd1 : 4'd2;
            #2; n_checks++;
            if (ctl !== want[i]) $display("FAIL drain_cyc%0d got %b want %b", i, ctl, want[i]); else n_pass++;
            step();
        end
        idle();
        wb_i = 1; wb_rd_name_i = 9;
        step();
        idle();
        #2; n_checks++;
        if (busy_vec_o !== 16'h0) $display("FAIL drain_clean got %h want 0000", busy_vec_o); else n_pass++;
    endtask

    task automatic test_error();
        wb_i = 1; wb_rd_name_i = 7;
        #2; n_checks++;
        if (err_o !== 1'b0) $display("FAIL err_before got %b want 0", err_o); else n_pass++;
        step();
        wb_i = 0;
        #2; n_checks++;
        if (err_o !== 1'b1) $display("FAIL err_set got %b want 1", err_o); else n_pass++;
        repeat (3) step();
        n_checks++;
        if (err_o !== 1'b1) $display("FAIL err_sticky got %b want 1", err_o); else n_pass++;
    endtask

    task automatic test_reset_mid();
        id_v_i = 1; id_rd_wb_i = 1; id_rd_name_i = 10;
        step();
        id_rd_name_i = 11;
        step();
        id_rd_wb_i = 0; branch_i = 1;
        #2; rst = 0; #1;
        n_checks++;
        if ({ctl, rd_reserved_o, rs_reserved_o, err_o, busy_vec_o} !== 23'h0)
            $display("FAIL reset_mid got %h want 0", {ctl, rd_reserved_o, rs_reserved_o, err_o, busy_vec_o});
        else n_pass++;
        step();
        rst = 1;
        idle();
        id_v_i = 1; id_rd_read_i = 1; id_rd_name_i = 10;
        #2; n_checks++;
        if ({ctl, err_o, busy_vec_o} !== {4'b1000, 1'b0, 16'h0})
            $display("FAIL reset_release got %h want %h", {ctl, err_o, busy_vec_o}, {4'b1000, 1'b0, 16'h0});
        else n_pass++;
        step();
        idle();
    endtask

    task automatic test_random();
        int cnt [16];
        int mode;
        int fl;
        int k;
        logic e_iss, e_stl, e_fl, e_dn;
        logic [15:0] e_busy;
        logic rdh, rsh, sat, nobusy;
        for (int r = 0; r < 16; r++) cnt[r] = 0;
        mode = 0;
        fl = 0;
        for (int c = 0; c < 500; c++) begin
            id_v_i       = ($urandom_range(0, 3) != 0);
            id_rd_read_i = 1'($urandom_range(0, 1));
            id_rs_read_i = 1'($urandom_range(0, 1));
            id_rd_wb_i   = ($urandom_range(0, 3) != 0);
            id_rd_name_i = 4'($urandom_range(0, 3));
            id_rs_name_i = 4'($urandom_range(0, 3));
            ex_busy_i    = ($urandom_range(0, 3) == 0);
            branch_i     = ($urandom_range(0, 9) == 0);
            drain_req_i  = ($urandom_range(0, 7) == 0);
            k = $urandom_range(0, 3);
            wb_i = (cnt[k] > 0) && ($urandom_range(0, 2) != 0);
            wb_rd_name_i = 4'(k);
            #2;
            e_busy = '0;
            for (int r = 0; r < 16; r++) e_busy[r] = (cnt[r] != 0);
            nobusy = (e_busy == 16'h0);
            rdh = id_rd_read_i && cnt[id_rd_name_i] > 0;
            rsh = id_rs_read_i && cnt[id_rs_name_i] > 0;
            sat = id_rd_wb_i && cnt[id_rd_name_i] == 3;
            e_iss = 0; e_stl = 0; e_fl = 0; e_dn = 0;
            if (mode == 0) begin
                e_iss = id_v_i && !rdh && !rsh && !sat && !ex_busy_i && !branch_i;
                e_stl = id_v_i && !e_iss && !branch_i;
                e_fl  = branch_i;
            end else if (mode == 1) begin
                e_fl = 1;
            end else begin
                e_stl = id_v_i;
                e_fl  = branch_i;
                e_dn  = !branch_i && nobusy && !wb_i;
            end
            n_checks++;
            if ({ctl, rd_reserved_o, rs_reserved_o, err_o, busy_vec_o} !==
                {e_iss, e_stl, e_fl, e_dn, cnt[id_rd_name_i] != 0, cnt[id_rs_name_i] != 0, 1'b0, e_busy})
                $display("FAIL rand_cyc%0d got %h want %h", c,
                         {ctl, rd_reserved_o, rs_reserved_o, err_o, busy_vec_o},
                         {e_iss, e_stl, e_fl, e_dn, cnt[id_rd_name_i] != 0, cnt[id_rs_name_i] != 0, 1'b0, e_busy});
            else n_pass++;
            if (e_iss && id_rd_wb_i) cnt[id_rd_name_i]++;
            if (wb_i) cnt[wb_rd_name_i]--;
            if (branch_i) begin
                mode = 1;
                fl = 1;
            end else if (mode == 1) begin
                fl--;
                if (fl == 0) mode = 0;
            end else if (mode == 0 && drain_req_i) begin
                mode = 2;
            end else if (mode == 2 && e_dn) begin
                mode = 0;
            end
            step();
        end
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset_init();
        test_raw();
        test_saturation();
        test_branch();
        test_drain();
        test_error();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
